// File: rtl/fp_divider_seq_pkg.sv
// Shared single-precision FPU definitions: format constants, divider FSM states, packing helpers.
package fp_divider_seq_pkg;

  localparam logic signed [9:0] FP_EXP_BIAS = 10'sd127;
  localparam logic [7:0]        FP_EXP_MAX  = 8'd255;
  localparam int                FP_FRAC_W   = 23;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fp_state_e;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, FP_POS_INF[30:0]};
  endfunction

  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, FP_ZERO[30:0]};
  endfunction

endpackage

// File: rtl/fp_divider_seq_mant_step.sv
// One restoring radix-2 divide step: compare/subtract the divisor, then shift the remainder left.
// Purely combinational; no handshake.
module fp_div_mant_step (
  input  logic [24:0] r,
  input  logic [23:0] mb,
  output logic [24:0] r_next,
  output logic        qbit
);

  logic [23:0] diff;

  // The remainder stays below 2*mb, so after a successful subtract it fits in 24 bits,
  // and when no subtract happens r[24] is already zero.
  always_comb begin
    qbit   = (r >= {1'b0, mb});
    diff   = qbit ? (r[23:0] - mb) : r[23:0];
    r_next = {diff, 1'b0};
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Iterative single-precision divider, truncating, denormals flushed; 26 cycles to out_valid (1 for specials).
// Accepts only in IDLE; the result and flags are held in DONE until out_ready.
module fp_divider_seq
  import fp_divider_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  fp_state_e         state;
  logic              sign;
  logic [23:0]       mb;
  logic [24:0]       rem;
  logic [24:0]       quo;
  logic [4:0]        count;
  logic signed [9:0] exp_q;

  logic [7:0]        ea;
  logic [7:0]        eb;
  logic              sign_in;
  logic signed [9:0] exp_in;

  logic [24:0]       rem_next;
  logic              qbit;

  logic signed [9:0]     e_norm;
  logic [FP_FRAC_W-1:0]  frac;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign sign_in = a[31] ^ b[31];
  assign exp_in  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + FP_EXP_BIAS;

  fp_div_mant_step u_step (
    .r      (rem),
    .mb     (mb),
    .r_next (rem_next),
    .qbit   (qbit)
  );

  // quo holds ma/mb scaled by 2^24, a value in (0.5, 2)
  always_comb begin
    if (quo[24]) begin
      frac   = quo[23:1];
      e_norm = exp_q;
    end else begin
      frac   = quo[22:0];
      e_norm = exp_q - 10'sd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= FP_ZERO;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      count       <= 5'd0;
      sign        <= 1'b0;
      mb          <= 24'd0;
      rem         <= 25'd0;
      quo         <= 25'd0;
      exp_q       <= 10'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            if (eb == 8'd0) begin
              result      <= fp_inf(sign_in);
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else if (ea == 8'd0) begin
              result    <= fp_zero(sign_in);
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (ea == FP_EXP_MAX || eb == FP_EXP_MAX) begin
              result    <= fp_inf(sign_in);
              overflow  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sign  <= sign_in;
              rem   <= {2'b01, a[22:0]};
              mb    <= {1'b1, b[22:0]};
              quo   <= 25'd0;
              count <= 5'd0;
              exp_q <= exp_in;
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (count == 5'd25) begin
            count     <= 5'd0;
            out_valid <= 1'b1;
            state     <= DONE;
            if (e_norm >= $signed({2'b00, FP_EXP_MAX})) begin
              result   <= fp_inf(sign);
              overflow <= 1'b1;
            end else if (e_norm <= 10'sd0) begin
              result    <= fp_zero(sign);
              underflow <= 1'b1;
            end else begin
              result <= {sign, e_norm[7:0], frac};
            end
          end else begin
            rem   <= rem_next;
            quo   <= {quo[23:0], qbit};
            count <= count + 5'd1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: directed corner cases plus random operands against an arithmetic reference.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  fp_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer quotient of the 24-bit significands scaled by 2^24,
  // truncated, then placed into the single-precision format.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic dz, output logic ov,
                         output logic uf, output int lat);
    int          ex, ey, e;
    longint      mx, my, q;
    logic        s;
    logic [22:0] fr;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    dz = 1'b0; ov = 1'b0; uf = 1'b0;
    if (ey == 0) begin
      res = {s, 8'hFF, 23'd0}; dz = 1'b1; lat = 1;
    end else if (ex == 0) begin
      res = {s, 31'd0}; lat = 1;
    end else if (ex == 255 || ey == 255) begin
      res = {s, 8'hFF, 23'd0}; ov = 1'b1; lat = 1;
    end else begin
      lat = 26;
      mx = longint'(x[22:0]) + 64'sd8388608;
      my = longint'(y[22:0]) + 64'sd8388608;
      q  = (mx * 64'sd16777216) / my;
      e  = ex - ey + 127;
      if (q >= 64'sd16777216) begin
        fr = 23'(q >> 1);
      end else begin
        fr = 23'(q);
        e  = e - 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0}; ov = 1'b1;
      end else if (e <= 0) begin
        res = {s, 31'd0}; uf = 1'b1;
      end else begin
        res = {s, 8'(e), fr};
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input bit poke);
    logic [31:0] er;
    logic        edz, eov, euf;
    int          elat, lat;
    ref_div(x, y, er, edz, eov, euf, elat);
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = cyc;
        break;
      end
      if (poke && cyc >= 4 && cyc <= 6)
        chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      if (poke && cyc == 3) begin
        in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h0000_0000;
      end
      if (poke && cyc == 6) in_valid = 1'b0;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " result"}, result, er);
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    chk({tag, " overflow"}, 32'(overflow), 32'(eov));
    chk({tag, " underflow"}, 32'(underflow), 32'(euf));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " held result"}, result, er);
      chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          mode;

    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("6/2", 32'h40C0_0000, 32'h4000_0000, 0, 1'b0);
    chk("6/2 literal", 32'h4040_0000, result);
    run_op("1/3", 32'h3F80_0000, 32'h4040_0000, 0, 1'b0);
    chk("1/3 literal", 32'h3EAA_AAAA, result);
    run_op("-2/1", 32'hC000_0000, 32'h3F80_0000, 0, 1'b0);
    run_op("1/0", 32'h3F80_0000, 32'h0000_0000, 0, 1'b0);
    run_op("overflow", 32'h7F00_0000, 32'h0080_0000, 0, 1'b0);
    run_op("underflow", 32'h0080_0000, 32'h7F00_0000, 0, 1'b0);
    run_op("0/x", 32'h8000_0000, 32'h3F80_0000, 0, 1'b0);
    run_op("inf/x", 32'h7F80_0000, 32'h3F80_0000, 0, 1'b0);
    run_op("backpressure", 32'h4120_0000, 32'h40E0_0000, 10, 1'b1);
    run_op("special hold", 32'h3F80_0000, 32'h0000_0000, 3, 1'b0);

    // Reset mid-CALC: count reaches 12 after 12 edges past the accept edge.
    @(negedge clk);
    a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after abort 6/2", 32'h40C0_0000, 32'h4000_0000, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: rb[30:23] = 8'd0;
        1: ra[30:23] = 8'd0;
        2: ra[30:23] = 8'd255;
        3: begin
          ra[30:23] = 8'($urandom_range(1, 20));
          rb[30:23] = 8'($urandom_range(230, 254));
          if ($urandom_range(0, 1) == 1) begin
            ra[30:23] = rb[30:23];
            rb[30:23] = 8'($urandom_range(1, 20));
          end
        end
        default: begin
          ra[30:23] = 8'($urandom_range(64, 190));
          rb[30:23] = 8'($urandom_range(64, 190));
        end
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
